// File: rtl/register_file.sv
// 32 x 32-bit MIPS register file: two combinational read ports, one synchronous write port,
// a bypass-free debug read port and a committed-write counter. Optional macro: RF_BYPASS_EN.
module register_file #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              enable,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_a,
   output logic [DATA_W-1:0] rd_data_b,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   output logic [31:0]       wr_count
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] r_mem [0:DEPTH-1];
   logic [31:0]       r_wr_count;

   logic              w_wr_commit;
   logic [DATA_W-1:0] w_stored_a;
   logic [DATA_W-1:0] w_stored_b;
   logic [DATA_W-1:0] w_stored_dbg;

   // A write to $zero is not a commit: it neither updates storage nor counts.
   assign w_wr_commit = enable & wr_en & (wr_addr != '0);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_count <= '0;
      end else if (w_wr_commit) begin
         r_mem[wr_addr] <= wr_data;
         r_wr_count     <= r_wr_count + 32'd1;
      end
   end

   assign w_stored_a   = r_mem[rd_addr_a];
   assign w_stored_b   = r_mem[rd_addr_b];
   assign w_stored_dbg = r_mem[dbg_addr];

`ifdef RF_BYPASS_EN
   logic w_byp_a;
   logic w_byp_b;

   // Write-first forwarding closes the WB->ID hazard; a write lost to reset must not leak through.
   assign w_byp_a = reset_n & w_wr_commit & (wr_addr == rd_addr_a);
   assign w_byp_b = reset_n & w_wr_commit & (wr_addr == rd_addr_b);

   assign rd_data_a = (rd_addr_a == '0) ? '0 : (w_byp_a ? wr_data : w_stored_a);
   assign rd_data_b = (rd_addr_b == '0) ? '0 : (w_byp_b ? wr_data : w_stored_b);
`else
   assign rd_data_a = (rd_addr_a == '0) ? '0 : w_stored_a;
   assign rd_data_b = (rd_addr_b == '0) ? '0 : w_stored_b;
`endif

   assign dbg_data = (dbg_addr == '0) ? '0 : w_stored_dbg;
   assign wr_count = r_wr_count;

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: a driver pushes model predictions per cycle,
// a monitor pops and compares them against the combinational outputs at the falling edge.
module tb_register_file;

   logic        clk;
   logic        reset_n;
   logic        enable;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [4:0]  rd_addr_a;
   logic [4:0]  rd_addr_b;
   logic [31:0] rd_data_a;
   logic [31:0] rd_data_b;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_data;
   logic [31:0] wr_count;

   register_file dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .enable    (enable),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_addr_a (rd_addr_a),
      .rd_addr_b (rd_addr_b),
      .rd_data_a (rd_data_a),
      .rd_data_b (rd_data_b),
      .dbg_addr  (dbg_addr),
      .dbg_data  (dbg_data),
      .wr_count  (wr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] dbg;
      logic [31:0] cnt;
   } exp_t;

   exp_t        sb_q[$];
   int          n_checks = 0;
   int          n_pass   = 0;
   logic [31:0] m_reg [32];
   logic [31:0] m_cnt;
   bit          m_known = 0;
   bit          drv_done = 0;

`ifdef RF_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   function automatic logic [31:0] port_value(input logic [4:0] ra, input bit fwd,
                                              input logic [4:0] wa, input logic [31:0] wd);
      if (ra == 5'd0) return 32'h0;
      if (fwd && wa == ra) return wd;
      return m_reg[ra];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %08h, expected %08h", name, act, req);
   endtask

   // One clock cycle: drive, predict this cycle's outputs, then advance the model across the edge.
   task automatic step(input bit rst_n, input bit en, input bit we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] ra, input logic [4:0] rb,
                       input logic [4:0] da);
      exp_t e;
      bit   commit;
      @(posedge clk);
      #1;
      reset_n = rst_n; enable = en; wr_en = we; wr_addr = wa; wr_data = wd;
      rd_addr_a = ra; rd_addr_b = rb; dbg_addr = da;
      commit = rst_n && en && we && (wa != 5'd0);
      if (m_known) begin
         e.a   = port_value(ra, BYPASS && commit, wa, wd);
         e.b   = port_value(rb, BYPASS && commit, wa, wd);
         e.dbg = port_value(da, 1'b0, wa, wd);
         e.cnt = m_cnt;
         sb_q.push_back(e);
      end
      if (!rst_n) begin
         foreach (m_reg[i]) m_reg[i] = 32'h0;
         m_cnt   = 32'h0;
         m_known = 1;
      end else if (commit) begin
         m_reg[wa] = wd;
         m_cnt     = m_cnt + 1;
      end
   endtask

   // Monitor: compare the oldest prediction against the outputs, mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("rd_data_a", rd_data_a, e.a);
            check("rd_data_b", rd_data_b, e.b);
            check("dbg_data",  dbg_data,  e.dbg);
            check("wr_count",  wr_count,  e.cnt);
         end
      end
   end

   initial begin
      reset_n = 1; enable = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
      rd_addr_a = 0; rd_addr_b = 0; dbg_addr = 0;

      step(0, 1, 0, 0, 0, 0, 0, 0);
      // Preload r5, then reset colliding with a write to r4
      step(1, 1, 1, 5, 32'h12345678, 5, 5, 5);
      step(1, 1, 0, 0, 0, 5, 5, 5);
      step(0, 1, 1, 4, 32'h5, 5, 4, 5);
      for (int i = 0; i < 32; i++) step(1, 1, 0, 0, 0, 5'(i), 5'(31 - i), 5'(i));
      // Basic write/read
      step(1, 1, 1, 7, 32'hDEADBEEF, 0, 0, 0);
      step(1, 1, 0, 0, 0, 7, 7, 7);
      // $zero
      step(1, 1, 1, 0, 32'hFFFFFFFF, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0, 0, 0);
      // Freeze then real write to r3
      step(1, 0, 1, 3, 32'hA5A5A5A5, 3, 3, 3);
      step(1, 1, 0, 0, 0, 3, 3, 3);
      step(1, 1, 1, 3, 32'hA5A5A5A5, 3, 0, 3);
      step(1, 1, 0, 0, 0, 3, 3, 3);
      // Same-cycle RAW on r9
      step(1, 1, 1, 9, 32'h11111111, 0, 0, 0);
      step(1, 1, 1, 9, 32'h22222222, 9, 9, 9);
      step(1, 1, 0, 0, 0, 9, 9, 9);
      // Bypass suppressed by freeze and by reset
      step(1, 0, 1, 9, 32'h33333333, 9, 9, 9);
      step(0, 1, 1, 9, 32'h44444444, 9, 9, 9);
      step(1, 1, 0, 0, 0, 9, 9, 9);

      // Counter wrap: preset to all-ones while frozen, then commit one write
      @(posedge clk);
      #2;
      force dut.r_wr_count = 32'hFFFFFFFF;
      m_cnt = 32'hFFFFFFFF;
      step(1, 0, 0, 0, 0, 1, 2, 3);
      release dut.r_wr_count;
      m_cnt = 32'hFFFFFFFF;
      step(1, 1, 1, 12, 32'hCAFEF00D, 12, 1, 12);
      step(1, 1, 0, 0, 0, 12, 12, 12);

      // Randomized traffic on a narrow address window to provoke collisions
      for (int i = 0; i < 400; i++) begin
         logic [4:0] wa;
         logic [4:0] ra;
         logic [4:0] rb;
         logic [4:0] da;
         wa = 5'($urandom_range(0, 7));
         ra = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
         rb = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 7));
         da = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
         step(($urandom_range(0, 49) != 0), ($urandom_range(0, 4) != 0),
              ($urandom_range(0, 9) < 7), wa, $urandom, ra, rb, da);
      end
      drv_done = 1;
   end

   initial begin
      fork
         begin
            wait (drv_done);
            repeat (3) @(posedge clk);
            check("scoreboard_drain", 32'(sb_q.size()), 32'h0);
         end
         begin
            #200000;
            $display("FAIL timeout: driver did not complete, pending %0d", sb_q.size());
            n_checks++;
         end
      join_any
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- 32 x 32-bit MIPS general-purpose register file in the ID stage.
- Drives the rs/rt operand values into the ID operand-select multiplexers; the WB stage writes results back into it.
- Provides two combinational read ports, one synchronous write port, and one debug read port for the debug unit.
- Includes a committed-write counter for debug stepping.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; depth = 2**ADDR_W = 32.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- enable  in  1  pipeline-run enable from the debug unit; low freezes all state.
- wr_en  in  1  WB-stage RegWrite.
- wr_addr  in  5  WB destination register.
- wr_data  in  32  WB result.
- rd_addr_a  in  5  rs index.
- rd_addr_b  in  5  rt index.
- rd_data_a  out  32  rs value, combinational.
- rd_data_b  out  32  rt value, combinational.
- dbg_addr  in  5  debug-unit register select.
- dbg_data  out  32  debug read value, combinational, no bypass.
- wr_count  out  32  number of committed writes since reset.

Behaviour:
- Reset: on a rising clk edge with reset_n=0, all 32 registers clear to 0x00000000 and wr_count clears to 0.
  - Reset has priority over enable and wr_en.
  - A write presented in the same cycle as reset is discarded.
- Write commit: a write commits at the rising edge when reset_n=1, enable=1, wr_en=1 and wr_addr!=0.
  - Storage is updated at that edge.
  - wr_count increments by 1 at that edge, wrapping 0xFFFFFFFF -> 0 with no flag.
- $zero:
  - Writes to register 0 are ignored and do not increment wr_count.
  - Register 0 always reads 0x00000000 on every port, bypass included.
- Freeze: enable=0 blocks writes and counting. Reads stay live.
- Read ports: purely combinational from storage, so latency is 0 cycles.
  - A committed value appears on a read port in the cycle after the commit edge.
- Simultaneous read/write: same cycle, same address on rd_addr_x and wr_addr, nonzero, write qualified (enable=1, wr_en=1).
  - Behaviour depends on RF_BYPASS_EN; see Optional Feature.
- Both read ports may address the same register; each returns the same value independently.
- dbg_data always returns stored contents: no bypass, and it ignores enable.
- Reads during the reset cycle return the pre-reset stored values. Storage reads zero from the next cycle.
- No X propagation: all 32 registers are defined out of reset.

Optional Feature:
- Macro: RF_BYPASS_EN
- Defined (write-first bypass):
  - When a qualified write (enable=1, wr_en=1, wr_addr!=0) targets the same address as rd_addr_a or rd_addr_b in the same cycle, that port outputs wr_data combinationally.
  - This removes the WB->ID hazard.
  - Bypass is suppressed when enable=0 or reset_n=0.
- Undefined:
  - Read ports return stored (old) contents in that cycle.
  - The new value is visible from the next cycle.
  - The hazard unit must stall one cycle for WB->ID dependencies.

Test Plan:
- Reset clear: preload r5=0x12345678, assert reset_n=0 for 1 cycle -> r0..r31 read 0x00000000 on all ports; wr_count=0.
- Basic write/read: write r7=0xDEADBEEF, then read rd_addr_a=7, rd_addr_b=7, dbg_addr=7 next cycle -> all ports 0xDEADBEEF; wr_count=1.
- Zero register: write r0=0xFFFFFFFF -> rd_data_a with rd_addr_a=0 reads 0x00000000; wr_count unchanged.
- Freeze: enable=0, wr_en=1, write r3=0xA5A5A5A5 -> r3 stays 0, wr_count unchanged. Repeat with enable=1 -> r3=0xA5A5A5A5, wr_count +1.
- Same-cycle RAW: r9=0x11111111 stored; in one cycle write r9=0x22222222 with rd_addr_a=9.
  - With RF_BYPASS_EN: rd_data_a=0x22222222 in that cycle.
  - Without RF_BYPASS_EN: rd_data_a=0x11111111, then 0x22222222 next cycle.
  - In both builds dbg_data=0x11111111 in that cycle.
- Reset vs write collision: reset_n=0 with wr_en=1, wr_addr=4, wr_data=0x5 -> r4=0 and wr_count=0 after the edge.
  - Separately, force wr_count to 0xFFFFFFFF via 2^32-1 writes (or a hierarchical force) and do one write -> wr_count=0.
